// File: rtl/reducao_media_in_pkg.sv
// Shared definitions for the 2x scaling path: frame limits, widths and FSM states.
package reducao_media_in_pkg;

  localparam int LARGURA_MAXIMA_DEF = 640;
  localparam int PIXEL_W_DEF        = 8;
  localparam int DIM_W              = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAR   = 2'd1,
    S_IMPAR = 2'd2
  } estado_t;

  // Clamp a requested width to the line-buffer capacity.
  function automatic logic [DIM_W-1:0] limita_largura(input logic [DIM_W-1:0] pedida,
                                                      input logic [DIM_W-1:0] maxima);
    return (pedida > maxima) ? maxima : pedida;
  endfunction

endpackage

// File: rtl/reducao_media_in_buffer_linha_somas.sv
// Line buffer holding the horizontal pair sums of the previous even row.
// One write port, one registered read port; read data holds while rd_en is low.
module reducao_media_in_buffer_linha_somas #(
  parameter int PROF = 320,
  parameter int LARG = 9,
  parameter int AW   = $clog2(PROF)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [LARG-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [LARG-1:0] rd_data
);

  logic [LARG-1:0] mem [PROF];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; the value is kept until the next read enable
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/reducao_media_in.sv
// 2x downscaler: averages every 2x2 block of a raster stream into one rounded pixel.
// Even rows store pair sums in the line buffer; odd rows add their pair to the stored
// sum and emit (sum + 2) >> 2. Trailing odd column/row are consumed and dropped.
module reducao_media_in
  import reducao_media_in_pkg::*;
#(
  parameter int LARGURA_MAXIMA = LARGURA_MAXIMA_DEF,
  parameter int PIXEL_W        = PIXEL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DIM_W-1:0]   largura_in,
  input  logic [DIM_W-1:0]   altura_in,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               pixel_in_valid,
  output logic               pixel_in_ready,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_out_valid,
  output logic               processing_done,
  output logic               busy
);

  localparam int PROF    = LARGURA_MAXIMA / 2;
  localparam int AW      = $clog2(PROF);
  localparam int SOMA2_W = PIXEL_W + 1;
  localparam int SOMA3_W = PIXEL_W + 2;
  localparam logic [DIM_W-1:0] LARG_MAX = DIM_W'(LARGURA_MAXIMA);
  localparam logic [DIM_W-1:0] DIM_MIN  = DIM_W'(2);
  localparam logic [DIM_W-1:0] UM       = DIM_W'(1);

  estado_t              estado;
  logic [DIM_W-1:0]     largura_reg;
  logic [DIM_W-1:0]     altura_reg;
  logic [DIM_W-1:0]     x;
  logic [DIM_W-1:0]     y;
  logic [PIXEL_W-1:0]   p0;
  logic [DIM_W-1:0]     largura_lim;
  logic [SOMA2_W-1:0]   soma_par;
  logic [SOMA2_W-1:0]   soma_linha_ant;
  logic [SOMA3_W-1:0]   soma_bloco;
  logic [PIXEL_W-1:0]   media;
  logic [AW-1:0]        buf_addr;
  logic                 aceita;
  logic                 fim_linha;
  logic                 fim_quadro;
  logic                 buf_wr;
  logic                 buf_rd;

  assign largura_lim    = limita_largura(largura_in, LARG_MAX);
  assign pixel_in_ready = (estado == S_PAR) || (estado == S_IMPAR);
  assign busy           = (estado != S_IDLE);
  assign aceita         = pixel_in_valid && pixel_in_ready;
  assign fim_linha      = (x == largura_reg - UM);
  assign fim_quadro     = fim_linha && (y == altura_reg - UM);

  // Both the write (odd column, even row) and the read (even column, odd row)
  // use the pair index, so the read lands one accept ahead of its use.
  assign buf_addr = AW'(x >> 1);
  assign buf_wr   = aceita && x[0] && (estado == S_PAR);
  assign buf_rd   = aceita && !x[0] && (estado == S_IMPAR);

  assign soma_par   = SOMA2_W'(p0) + SOMA2_W'(pixel_in);
  assign soma_bloco = SOMA3_W'(soma_linha_ant) + SOMA3_W'(p0) + SOMA3_W'(pixel_in);
  assign media      = PIXEL_W'((soma_bloco + SOMA3_W'(2)) >> 2);

  reducao_media_in_buffer_linha_somas #(
    .PROF (PROF),
    .LARG (SOMA2_W),
    .AW   (AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_addr (buf_addr),
    .wr_data (soma_par),
    .rd_en   (buf_rd),
    .rd_addr (buf_addr),
    .rd_data (soma_linha_ant)
  );

  // Frame FSM, raster counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      estado          <= S_IDLE;
      largura_reg     <= '0;
      altura_reg      <= '0;
      x               <= '0;
      y               <= '0;
      p0              <= '0;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      processing_done <= 1'b0;
    end else begin
      pixel_out_valid <= 1'b0;
      processing_done <= 1'b0;
      case (estado)
        S_IDLE: begin
          if (start) begin
            largura_reg <= largura_lim;
            altura_reg  <= altura_in;
            x           <= '0;
            y           <= '0;
            // Frames too small to hold a single 2x2 block finish immediately.
            if ((largura_lim < DIM_MIN) || (altura_in < DIM_MIN)) begin
              processing_done <= 1'b1;
            end else begin
              estado <= S_PAR;
            end
          end
        end
        S_PAR, S_IMPAR: begin
          if (aceita) begin
            if (!x[0]) begin
              p0 <= pixel_in;
            end else if (estado == S_IMPAR) begin
              pixel_out       <= media;
              pixel_out_valid <= 1'b1;
            end
            if (fim_linha) begin
              x <= '0;
              y <= y + UM;
              if (fim_quadro) begin
                estado          <= S_IDLE;
                processing_done <= 1'b1;
              end else begin
                estado <= (estado == S_PAR) ? S_IMPAR : S_PAR;
              end
            end else begin
              x <= x + UM;
            end
          end
        end
        default: estado <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reducao_media_in.sv
// Scoreboard bench for the 2x downscaler: the driver pushes expected averages,
// a negedge monitor pops and compares each pulsed output.
module tb_reducao_media_in;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] largura_in;
  logic [9:0] altura_in;
  logic [7:0] pixel_in;
  logic       pixel_in_valid;
  logic       pixel_in_ready;
  logic [7:0] pixel_out;
  logic       pixel_out_valid;
  logic       processing_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int out_cnt = 0;
  int exp_q[$];
  int frame_px[$];
  int mon_e;

  int f4x2 [8] = '{10, 20, 30, 40, 50, 60, 70, 80};
  int frnd [12] = '{1, 1, 1, 2, 255, 255, 1, 2, 2, 2, 255, 255};

  always #5 clk = ~clk;

  reducao_media_in dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .largura_in      (largura_in),
    .altura_in       (altura_in),
    .pixel_in        (pixel_in),
    .pixel_in_valid  (pixel_in_valid),
    .pixel_in_ready  (pixel_in_ready),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .processing_done (processing_done),
    .busy            (busy)
  );

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (pixel_out_valid === 1'b1) begin
      out_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0d with no output expected", pixel_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(pixel_out) != mon_e) begin
          errors++;
          $display("FAIL pixel_out: got %0d, expected %0d", pixel_out, mon_e);
        end
      end
    end
    if (processing_done === 1'b1) done_cnt++;
  end

  // Reference: mean of each complete 2x2 block whose last pixel is among the first n sent.
  task automatic push_model(int w, int h, int n);
    for (int by = 0; by < h / 2; by++) begin
      for (int bx = 0; bx < w / 2; bx++) begin
        int i0;
        int i1;
        i0 = 2 * by * w + 2 * bx;
        i1 = i0 + w;
        if (i1 + 1 < n)
          exp_q.push_back((frame_px[i0] + frame_px[i0 + 1] + frame_px[i1] + frame_px[i1 + 1] + 2) / 4);
      end
    end
  endtask

  task automatic start_frame(int w, int h);
    @(negedge clk);
    start = 1'b1;
    largura_in = 10'(w);
    altura_in = 10'(h);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends the first n pixels of frame_px with random gaps and stray start pulses.
  // Returns at the negedge following the last accept.
  task automatic drive_frame(int n, int gap_pct, output int accepted);
    int idx = 0;
    int budget = 0;
    bit acc;
    while (idx < n && budget < 20000) begin
      @(negedge clk);
      pixel_in_valid = ($urandom_range(99) >= gap_pct);
      pixel_in = pixel_in_valid ? 8'(frame_px[idx]) : 8'($urandom_range(255));
      start = ($urandom_range(15) == 0);
      largura_in = 10'($urandom_range(1023));
      acc = pixel_in_valid && pixel_in_ready;
      @(posedge clk);
      if (acc) idx++;
      budget++;
    end
    @(negedge clk);
    pixel_in_valid = 1'b0;
    start = 1'b0;
    accepted = idx;
    if (idx < n) check("drive_timeout_accepted", idx, n);
  endtask

  task automatic run_frame(int w_in, int h_in, int gap, string tag);
    int w_eff;
    int n;
    int acc;
    int d0;
    int o0;
    int n_out;
    w_eff = (w_in > 640) ? 640 : w_in;
    n = w_eff * h_in;
    n_out = (w_eff >= 2 && h_in >= 2) ? (w_eff / 2) * (h_in / 2) : 0;
    d0 = done_cnt;
    o0 = out_cnt;
    start_frame(w_in, h_in);
    if (w_eff < 2 || h_in < 2) begin
      check({tag, "_done_after_start"}, int'(processing_done), 1);
      check({tag, "_busy_idle"}, int'(busy), 0);
    end else begin
      check({tag, "_busy_started"}, int'(busy), 1);
      check({tag, "_ready_started"}, int'(pixel_in_ready), 1);
      drive_frame(n, gap, acc);
      check({tag, "_done_after_last"}, int'(processing_done), 1);
      check({tag, "_busy_end"}, int'(busy), 0);
      if (w_eff % 2 == 0 && h_in % 2 == 0)
        check({tag, "_valid_with_done"}, int'(pixel_out_valid), 1);
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_out_count"}, out_cnt - o0, n_out);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic load_ramp(int n);
    frame_px.delete();
    for (int i = 0; i < n; i++) frame_px.push_back(i % 256);
  endtask

  task automatic load_random(int n);
    frame_px.delete();
    for (int i = 0; i < n; i++) frame_px.push_back(int'($urandom_range(255)));
  endtask

  initial begin
    int acc;
    int d0;
    int w;
    int h;
    reset = 1'b1;
    start = 1'b0;
    largura_in = '0;
    altura_in = '0;
    pixel_in = '0;
    pixel_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(pixel_in_ready), 0);
    check("rst_valid", int'(pixel_out_valid), 0);
    check("rst_done", int'(processing_done), 0);
    check("rst_pixel_out", int'(pixel_out), 0);
    reset = 1'b0;

    // Directed 4x2, back-to-back
    frame_px.delete();
    foreach (f4x2[i]) frame_px.push_back(f4x2[i]);
    exp_q.push_back(35);
    exp_q.push_back(55);
    run_frame(4, 2, 0, "f4x2");

    // Rounding blocks {1,1,1,2}->1, {1,2,2,2}->2, {255 x4}->255
    frame_px.delete();
    foreach (frnd[i]) frame_px.push_back(frnd[i]);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(255);
    run_frame(6, 2, 0, "round");

    // 5x3 ramp: odd width and odd height
    load_ramp(15);
    exp_q.push_back(3);
    exp_q.push_back(5);
    run_frame(5, 3, 0, "f5x3");

    // 640x4 ramp, back-to-back then with gaps
    load_ramp(2560);
    push_model(640, 4, 2560);
    run_frame(640, 4, 0, "ramp_b2b");
    load_ramp(2560);
    push_model(640, 4, 2560);
    run_frame(640, 4, 40, "ramp_gaps");

    // Width clamp
    load_random(1280);
    push_model(640, 2, 1280);
    run_frame(1000, 2, 20, "clamp");

    // Degenerate sizes
    frame_px.delete();
    run_frame(1, 5, 0, "w1");
    run_frame(8, 1, 0, "h1");

    // Random small frames
    for (int k = 0; k < 6; k++) begin
      w = int'($urandom_range(24, 2));
      h = int'($urandom_range(9, 2));
      load_random(w * h);
      push_model(w, h, w * h);
      run_frame(w, h, 30, "rnd");
    end

    // Reset in the middle of the second row
    load_ramp(2560);
    push_model(640, 4, 700);
    d0 = done_cnt;
    start_frame(640, 4);
    drive_frame(700, 25, acc);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", int'(pixel_in_ready), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(pixel_out_valid), 0);
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_queue_drained", exp_q.size(), 0);

    // Clean frame after reset
    frame_px.delete();
    foreach (f4x2[i]) frame_px.push_back(f4x2[i]);
    exp_q.push_back(35);
    exp_q.push_back(55);
    run_frame(4, 2, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
